// File: rtl/red_peak_detector.sv
// Hysteresis peak/valley tracker with beat-interval measurement for the RED channel.
// Optional running interval average is enabled with `define RED_PEAK_AVG_EN.
module red_peak_detector #(
  parameter logic [19:0] HYST         = 20'd256,
  parameter int          WARMUP       = 25,
  parameter logic [15:0] MIN_INTERVAL = 16'd50
) (
  input  logic        CLK_Filter,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [19:0] Filtered_In,
  output logic [19:0] Peak_Value,
  output logic [19:0] Valley_Value,
  output logic [19:0] Amplitude,
  output logic [15:0] Peak_Interval,
  output logic        beat_valid,
  output logic        no_beat
`ifdef RED_PEAK_AVG_EN
  ,
  output logic [15:0] Avg_Interval,
  output logic        avg_valid
`endif
);

  localparam logic [1:0] ST_WARMUP  = 2'd0;
  localparam logic [1:0] ST_RISING  = 2'd1;
  localparam logic [1:0] ST_FALLING = 2'd2;

  localparam int            WCW      = $clog2(WARMUP + 2);
  localparam logic [WCW-1:0] WARM_LIM = WCW'(WARMUP);

  logic [1:0]     state_q,  state_d;
  logic [WCW-1:0] warm_q,   warm_d;
  logic [19:0]    max_q,    max_d;
  logic [19:0]    min_q,    min_d;
  logic [15:0]    cnt_q,    cnt_d;
  logic           have_q,   have_d;
  logic [19:0]    peak_q,   peak_d;
  logic [19:0]    valley_q, valley_d;
  logic [19:0]    amp_q,    amp_d;
  logic [15:0]    ivl_q,    ivl_d;
  logic           beat_q,   beat_d;
  logic           nobeat_q, nobeat_d;

  logic [20:0] x21_s;
  logic [15:0] cnt_inc_s;
  logic [19:0] amp_calc_s;

  // Next-state logic for the peak/valley FSM, interval counter and outputs
  always_comb begin
    state_d    = state_q;
    warm_d     = warm_q;
    max_d      = max_q;
    min_d      = min_q;
    cnt_d      = cnt_q;
    have_d     = have_q;
    peak_d     = peak_q;
    valley_d   = valley_q;
    amp_d      = amp_q;
    ivl_d      = ivl_q;
    beat_d     = 1'b0;
    x21_s      = {1'b0, Filtered_In};
    cnt_inc_s  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    amp_calc_s = (max_q >= valley_q) ? (max_q - valley_q) : 20'd0;

    if (sample_valid) begin
      case (state_q)
        ST_WARMUP: begin
          if (warm_q < WARM_LIM) begin
            warm_d = warm_q + WCW'(1);
          end else begin
            max_d   = Filtered_In;
            min_d   = Filtered_In;
            state_d = ST_RISING;
          end
        end
        ST_RISING: begin
          cnt_d = cnt_inc_s;
          if (Filtered_In > max_q) begin
            max_d = Filtered_In;
          end else if ((x21_s + {1'b0, HYST}) < {1'b0, max_q}) begin
            min_d   = Filtered_In;
            state_d = ST_FALLING;
            // A saturated counter re-arms the detector without reporting a beat
            if (!have_q || (cnt_q == 16'hFFFF)) begin
              peak_d = max_q;
              have_d = 1'b1;
              cnt_d  = 16'd0;
            end else if (cnt_inc_s >= MIN_INTERVAL) begin
              peak_d = max_q;
              ivl_d  = cnt_inc_s;
              amp_d  = amp_calc_s;
              beat_d = 1'b1;
              cnt_d  = 16'd0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            max_d = max_q;
          end
        end
        ST_FALLING: begin
          cnt_d = cnt_inc_s;
          if (Filtered_In < min_q) begin
            min_d = Filtered_In;
          end else if (x21_s > ({1'b0, min_q} + {1'b0, HYST})) begin
            valley_d = min_q;
            max_d    = Filtered_In;
            state_d  = ST_RISING;
          end else begin
            min_d = min_q;
          end
        end
        default: begin
          state_d = ST_WARMUP;
        end
      endcase
    end else begin
      beat_d = 1'b0;
    end

    nobeat_d = have_d && (cnt_d == 16'hFFFF);
  end

  // State and output registers
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WARMUP;
      warm_q   <= '0;
      max_q    <= 20'd0;
      min_q    <= 20'hFFFFF;
      cnt_q    <= 16'd0;
      have_q   <= 1'b0;
      peak_q   <= 20'd0;
      valley_q <= 20'd0;
      amp_q    <= 20'd0;
      ivl_q    <= 16'd0;
      beat_q   <= 1'b0;
      nobeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      max_q    <= max_d;
      min_q    <= min_d;
      cnt_q    <= cnt_d;
      have_q   <= have_d;
      peak_q   <= peak_d;
      valley_q <= valley_d;
      amp_q    <= amp_d;
      ivl_q    <= ivl_d;
      beat_q   <= beat_d;
      nobeat_q <= nobeat_d;
    end
  end

  assign Peak_Value    = peak_q;
  assign Valley_Value  = valley_q;
  assign Amplitude     = amp_q;
  assign Peak_Interval = ivl_q;
  assign beat_valid    = beat_q;
  assign no_beat       = nobeat_q;

`ifdef RED_PEAK_AVG_EN
  logic [15:0] hist_q [4];
  logic [15:0] hist_d [4];
  logic [15:0] avg_q,    avg_d;
  logic        avgv_q,   avgv_d;
  logic [2:0]  nbeats_q, nbeats_d;
  logic [17:0] sum_s;

  // Interval history, cleared when the timeout indication rises
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hist_d[i] = hist_q[i];
    end
    avg_d    = avg_q;
    avgv_d   = avgv_q;
    nbeats_d = nbeats_q;
    sum_s    = {2'b00, cnt_inc_s} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    if (nobeat_d && !nobeat_q) begin
      for (int i = 0; i < 4; i++) begin
        hist_d[i] = 16'd0;
      end
      nbeats_d = 3'd0;
      avgv_d   = 1'b0;
    end else if (beat_d) begin
      hist_d[0] = cnt_inc_s;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
      avg_d     = sum_s[17:2];
      nbeats_d  = (nbeats_q >= 3'd4) ? 3'd4 : nbeats_q + 3'd1;
      avgv_d    = (nbeats_d >= 3'd4);
    end else begin
      avgv_d = avgv_q;
    end
  end

  // Average registers
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= 16'd0;
      end
      avg_q    <= 16'd0;
      avgv_q   <= 1'b0;
      nbeats_q <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
      avg_q    <= avg_d;
      avgv_q   <= avgv_d;
      nbeats_q <= nbeats_d;
    end
  end

  assign Avg_Interval = avg_q;
  assign avg_valid    = avgv_q;
`endif

endmodule

// File: tb/tb_red_peak_detector.sv
// Scoreboard bench for red_peak_detector: a behavioural model queues expected outputs per sample.
module tb_red_peak_detector;

  logic        CLK_Filter = 1'b0;
  logic        rst_n = 1'b1;
  logic        sample_valid = 1'b0;
  logic [19:0] Filtered_In = 20'd0;
  logic [19:0] Peak_Value, Valley_Value, Amplitude;
  logic [15:0] Peak_Interval;
  logic        beat_valid, no_beat;
`ifdef RED_PEAK_AVG_EN
  logic [15:0] Avg_Interval;
  logic        avg_valid;
`endif

  red_peak_detector dut (
    .CLK_Filter   (CLK_Filter),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .Filtered_In  (Filtered_In),
    .Peak_Value   (Peak_Value),
    .Valley_Value (Valley_Value),
    .Amplitude    (Amplitude),
    .Peak_Interval(Peak_Interval),
    .beat_valid   (beat_valid),
    .no_beat      (no_beat)
`ifdef RED_PEAK_AVG_EN
    ,
    .Avg_Interval (Avg_Interval),
    .avg_valid    (avg_valid)
`endif
  );

  always #5 CLK_Filter = ~CLK_Filter;

  typedef struct {
    int peak;
    int valley;
    int amp;
    int ivl;
    int beat;
    int nobeat;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int beats_seen = 0;

  // behavioural model state (0 warm-up, 1 rising, 2 falling)
  int m_state, m_wc, m_max, m_min, m_cnt, m_have;
  int m_peak, m_valley, m_amp, m_ivl, m_beat, m_nobeat;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wc = 0; m_max = 0; m_min = 20'hFFFFF; m_cnt = 0; m_have = 0;
    m_peak = 0; m_valley = 0; m_amp = 0; m_ivl = 0; m_beat = 0; m_nobeat = 0;
  endtask

  task automatic model_step(input bit v, input int x);
    int  p;
    bit  conf;
    m_beat = 0;
    if (!v) return;
    if (m_state == 0) begin
      if (m_wc < 25) m_wc++;
      else begin
        m_max = x; m_min = x; m_state = 1;
      end
      return;
    end
    p = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    conf = 0;
    if (m_state == 1) begin
      if (x > m_max) m_max = x;
      else if (x + 256 < m_max) begin
        conf = 1; m_min = x; m_state = 2;
      end
    end else begin
      if (x < m_min) m_min = x;
      else if (x > m_min + 256) begin
        m_valley = m_min; m_max = x; m_state = 1;
      end
    end
    if (conf && (!m_have || m_cnt == 65535)) begin
      m_peak = m_max; m_have = 1; m_cnt = 0;
    end else if (conf && p >= 50) begin
      m_peak = m_max; m_ivl = p; m_amp = (m_max > m_valley) ? m_max - m_valley : 0;
      m_beat = 1; m_cnt = 0;
    end else begin
      m_cnt = p;
    end
    m_nobeat = (m_have != 0 && m_cnt == 65535) ? 1 : 0;
  endtask

  task automatic step(input bit v, input int x);
    exp_t e;
    sample_valid = v;
    Filtered_In  = 20'(x);
    model_step(v, x);
    e.peak = m_peak; e.valley = m_valley; e.amp = m_amp;
    e.ivl = m_ivl; e.beat = m_beat; e.nobeat = m_nobeat;
    sb_q.push_back(e);
    @(posedge CLK_Filter);
    #1;
    sample_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_val("peak",   int'(Peak_Value),    e.peak);
      check_val("valley", int'(Valley_Value),  e.valley);
      check_val("amp",    int'(Amplitude),     e.amp);
      check_val("ivl",    int'(Peak_Interval), e.ivl);
      check_val("beat",   int'(beat_valid),    e.beat);
      check_val("nobeat", int'(no_beat),       e.nobeat);
    end
    if (beat_valid) beats_seen++;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_peak"},   int'(Peak_Value),    0);
    check_val({tag, "_valley"}, int'(Valley_Value),  0);
    check_val({tag, "_amp"},    int'(Amplitude),     0);
    check_val({tag, "_ivl"},    int'(Peak_Interval), 0);
    check_val({tag, "_beat"},   int'(beat_valid),    0);
    check_val({tag, "_nobeat"}, int'(no_beat),       0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    Filtered_In = 20'd0;
    #1;
    model_reset();
    sb_q.delete();
    check_zero("rst");
    @(posedge CLK_Filter);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int tri_val(input int i);
    int k;
    k = i % 100;
    return (k <= 50) ? 40 * k : 40 * (100 - k);
  endfunction

  initial begin
    int b0;
    #2;

    // warm-up with a constant input: nothing is ever reported
    do_reset();
    b0 = beats_seen;
    for (int i = 0; i < 225; i++) step(1'b1, 1000);
    check_val("warm_beats", beats_seen - b0, 0);
    check_zero("warm_end");

    // triangle wave with random idle cycles
    do_reset();
    b0 = beats_seen;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 12345);
      step(1'b1, tri_val(i));
      if (i == 57) begin
        check_val("tri_first_peak", int'(Peak_Value), 2000);
        check_val("tri_first_silent", int'(beat_valid), 0);
      end
      if (i == 157) check_val("tri_beat2", int'(beat_valid), 1);
    end
    check_val("tri_beats", beats_seen - b0, 5);
    check_val("tri_peak", int'(Peak_Value), 2000);
    check_val("tri_valley", int'(Valley_Value), 0);
    check_val("tri_amp", int'(Amplitude), 2000);
    check_val("tri_ivl", int'(Peak_Interval), 100);

    // refractory: silent peak of 1800, rejected 2000 at +30, accepted 2000 at +100
    do_reset();
    b0 = beats_seen;
    for (int i = 0; i < 26; i++) step(1'b1, 0);
    for (int v = 40; v <= 1800; v += 40) step(1'b1, v);
    for (int v = 1760; v >= 1520; v -= 40) step(1'b1, v);
    check_val("ref_c0_peak", int'(Peak_Value), 1800);
    step(1'b1, 1000);
    for (int i = 0; i < 26; i++) step(1'b1, 0);
    step(1'b1, 1000);
    step(1'b1, 2000);
    step(1'b1, 1000);
    check_val("ref_rej_beat", int'(beat_valid), 0);
    check_val("ref_rej_peak", int'(Peak_Value), 1800);
    for (int i = 0; i < 67; i++) step(1'b1, 0);
    step(1'b1, 1000);
    step(1'b1, 2000);
    step(1'b1, 1000);
    check_val("ref_acc_beat", int'(beat_valid), 1);
    check_val("ref_acc_ivl", int'(Peak_Interval), 100);
    check_val("ref_acc_peak", int'(Peak_Value), 2000);
    check_val("ref_acc_amp", int'(Amplitude), 2000);
    check_val("ref_beats", beats_seen - b0, 1);

    // hysteresis: small ripple confirms nothing
    do_reset();
    b0 = beats_seen;
    for (int i = 0; i < 26; i++) step(1'b1, 5000);
    for (int i = 0; i < 1000; i++) step(1'b1, (i % 2 == 0) ? 5100 : 4900);
    check_val("hyst_beats", beats_seen - b0, 0);
    check_zero("hyst_end");

    // timeout: flat input after a beat saturates the counter
    do_reset();
    for (int i = 0; i < 158; i++) step(1'b1, tri_val(i));
    check_val("to_pre_beat", int'(beat_valid), 1);
    for (int j = 1; j <= 70000; j++) begin
      step(1'b1, 1720);
      if (j == 65534) check_val("to_nobeat_early", int'(no_beat), 0);
      if (j == 65535) check_val("to_nobeat_set", int'(no_beat), 1);
    end
    check_val("to_nobeat_hold", int'(no_beat), 1);
    for (int k = 0; k < 200; k++) begin
      step(1'b1, tri_val(k));
      if (k == 57) begin
        check_val("to_rearm_silent", int'(beat_valid), 0);
        check_val("to_rearm_clear", int'(no_beat), 0);
      end
      if (k == 157) begin
        check_val("to_next_beat", int'(beat_valid), 1);
        check_val("to_next_ivl", int'(Peak_Interval), 100);
      end
    end

    // asynchronous reset while beat_valid is high
    do_reset();
    for (int i = 0; i < 158; i++) step(1'b1, tri_val(i));
    check_val("mid_beat_hi", int'(beat_valid), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_async");
    model_reset();
    sb_q.delete();
    @(posedge CLK_Filter);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, tri_val(i));
      if (i == 57) begin
        check_val("mid_restart_silent", int'(beat_valid), 0);
        check_val("mid_restart_peak", int'(Peak_Value), 2000);
        check_val("mid_restart_ivl", int'(Peak_Interval), 0);
      end
    end
    check_val("mid_restart_ivl_end", int'(Peak_Interval), 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
